// File: rtl/exmemwb_pipe.sv
// Execute / memory / writeback back end: ALU with carry and overflow flags, operand
// forwarding, load-use stall detection, data-memory strobes and register-file write port.
module exmemwb_pipe #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter bit FWD   = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic [AW-1:0]    id_rd,
  input  logic [WIDTH-1:0] id_a,
  input  logic [WIDTH-1:0] id_b,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_immsel,
  input  logic [2:0]       id_s,
  input  logic             id_cin,
  input  logic             id_lw,
  input  logic             id_sw,
  output logic             stall,
  output logic [WIDTH-1:0] daddr,
  output logic [WIDTH-1:0] dout,
  output logic             dwe,
  output logic             dre,
  input  logic [WIDTH-1:0] din,
  output logic             wb_we,
  output logic [AW-1:0]    wb_sel,
  output logic [WIDTH-1:0] wb_data,
  output logic             mem_cout,
  output logic             mem_v
);

  localparam logic [AW-1:0]    ZERO_A = {AW{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  // EX stage registers
  logic             ex_valid_r, ex_immsel_r, ex_cin_r, ex_lw_r, ex_sw_r;
  logic [AW-1:0]    ex_rs_r, ex_rt_r, ex_rd_r;
  logic [WIDTH-1:0] ex_a_r, ex_b_r, ex_imm_r;
  logic [2:0]       ex_s_r;
  // MEM stage registers (mem_wr_r/mem_lw_r/mem_sw_r already include valid)
  logic             mem_wr_r, mem_lw_r, mem_sw_r, mem_cout_r, mem_v_r;
  logic [AW-1:0]    mem_rd_r;
  logic [WIDTH-1:0] mem_res_r, mem_sd_r;
  // WB stage registers
  logic             wb_we_r;
  logic [AW-1:0]    wb_sel_r;
  logic [WIDTH-1:0] wb_data_r;

  logic             stall_s, ex_wr_s, cout_s, v_s;
  logic [WIDTH-1:0] cap_a_s, cap_b_s, fwd_a_s, fwd_b_s, bop_s, bp_s, res_s;
  logic [WIDTH:0]   sum_s;

  // Load-use hazard: consumer in ID needs a value the load in EX has not fetched yet
  always_comb begin
    stall_s = 1'b0;
    if (FWD && id_valid && ex_valid_r && ex_lw_r && (ex_rd_r != ZERO_A)) begin
      stall_s = (id_rs == ex_rd_r) || ((id_rt == ex_rd_r) && (!id_immsel || id_sw));
    end else begin
      stall_s = 1'b0;
    end
  end

  // Capture-time bypass covers the register file's write-then-read gap
  always_comb begin
    cap_a_s = id_a;
    cap_b_s = id_b;
    if (FWD && wb_we_r && (wb_sel_r == id_rs)) cap_a_s = wb_data_r;
    else                                       cap_a_s = id_a;
    if (FWD && wb_we_r && (wb_sel_r == id_rt)) cap_b_s = wb_data_r;
    else                                       cap_b_s = id_b;
  end

  // EX operand forwarding, MEM (younger producer) over WB; r0 never matches since
  // neither stage asserts a write for rd == 0
  always_comb begin
    fwd_a_s = ex_a_r;
    fwd_b_s = ex_b_r;
    if (FWD && mem_wr_r && !mem_lw_r && (mem_rd_r == ex_rs_r)) fwd_a_s = mem_res_r;
    else if (FWD && wb_we_r && (wb_sel_r == ex_rs_r))          fwd_a_s = wb_data_r;
    else                                                       fwd_a_s = ex_a_r;
    if (FWD && mem_wr_r && !mem_lw_r && (mem_rd_r == ex_rt_r)) fwd_b_s = mem_res_r;
    else if (FWD && wb_we_r && (wb_sel_r == ex_rt_r))          fwd_b_s = wb_data_r;
    else                                                       fwd_b_s = ex_b_r;
  end

  // ALU; codes 000-011 share one carry chain on b' = s[0] ? ~b : b
  always_comb begin
    bop_s  = ex_immsel_r ? ex_imm_r : fwd_b_s;
    bp_s   = ex_s_r[0] ? ~bop_s : bop_s;
    sum_s  = {1'b0, fwd_a_s} + {1'b0, bp_s} + {{WIDTH{1'b0}}, ex_cin_r};
    res_s  = ZERO_W;
    cout_s = 1'b0;
    v_s    = 1'b0;
    case (ex_s_r)
      3'b000, 3'b001: res_s = fwd_a_s ^ bp_s;
      3'b010, 3'b011: res_s = sum_s[WIDTH-1:0];
      3'b100:         res_s = fwd_a_s | bop_s;
      3'b101:         res_s = ~(fwd_a_s | bop_s);
      3'b110:         res_s = fwd_a_s & bop_s;
      default:        res_s = ZERO_W;
    endcase
    if (ex_s_r[2] == 1'b0) begin
      cout_s = sum_s[WIDTH];
      v_s    = sum_s[WIDTH] ^ (fwd_a_s[WIDTH-1] ^ bp_s[WIDTH-1] ^ sum_s[WIDTH-1]);
    end else begin
      cout_s = 1'b0;
      v_s    = 1'b0;
    end
  end

  assign ex_wr_s = ex_valid_r && !ex_sw_r && (ex_rd_r != ZERO_A);

  // Pipeline registers for EX, MEM and WB
  always_ff @(posedge clk) begin
    if (reset_n == 1'b0) begin
      ex_valid_r  <= 1'b0;
      ex_immsel_r <= 1'b0;
      ex_cin_r    <= 1'b0;
      ex_lw_r     <= 1'b0;
      ex_sw_r     <= 1'b0;
      ex_rs_r     <= ZERO_A;
      ex_rt_r     <= ZERO_A;
      ex_rd_r     <= ZERO_A;
      ex_a_r      <= ZERO_W;
      ex_b_r      <= ZERO_W;
      ex_imm_r    <= ZERO_W;
      ex_s_r      <= 3'b000;
      mem_wr_r    <= 1'b0;
      mem_lw_r    <= 1'b0;
      mem_sw_r    <= 1'b0;
      mem_cout_r  <= 1'b0;
      mem_v_r     <= 1'b0;
      mem_rd_r    <= ZERO_A;
      mem_res_r   <= ZERO_W;
      mem_sd_r    <= ZERO_W;
      wb_we_r     <= 1'b0;
      wb_sel_r    <= ZERO_A;
      wb_data_r   <= ZERO_W;
    end else begin
      if (id_valid && !stall_s) begin
        ex_valid_r  <= 1'b1;
        ex_immsel_r <= id_immsel;
        ex_cin_r    <= id_cin;
        ex_lw_r     <= id_lw;
        ex_sw_r     <= id_sw;
        ex_rs_r     <= id_rs;
        ex_rt_r     <= id_rt;
        ex_rd_r     <= id_rd;
        ex_a_r      <= cap_a_s;
        ex_b_r      <= cap_b_s;
        ex_imm_r    <= id_imm;
        ex_s_r      <= id_s;
      end else begin
        ex_valid_r  <= 1'b0;
      end
      mem_wr_r   <= ex_wr_s;
      mem_lw_r   <= ex_valid_r && ex_lw_r;
      mem_sw_r   <= ex_valid_r && ex_sw_r;
      mem_cout_r <= ex_valid_r && cout_s;
      mem_v_r    <= ex_valid_r && v_s;
      mem_rd_r   <= ex_rd_r;
      mem_res_r  <= res_s;
      mem_sd_r   <= fwd_b_s;
      wb_we_r    <= mem_wr_r;
      wb_sel_r   <= mem_rd_r;
      wb_data_r  <= mem_lw_r ? din : mem_res_r;
    end
  end

  assign stall    = stall_s;
  assign daddr    = mem_res_r;
  assign dout     = mem_sd_r;
  assign dwe      = mem_sw_r;
  assign dre      = mem_lw_r;
  assign mem_cout = mem_cout_r;
  assign mem_v    = mem_v_r;
  assign wb_we    = wb_we_r;
  assign wb_sel   = wb_sel_r;
  assign wb_data  = wb_data_r;

endmodule

// File: tb/tb_exmemwb_pipe.sv
// Directed bench for exmemwb_pipe: forwarding, load-use stall, stores, flags, r0 and reset.
module tb_exmemwb_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_a, id_b, id_imm;
  logic        id_immsel;
  logic [2:0]  id_s;
  logic        id_cin, id_lw, id_sw;
  logic        stall;
  logic [31:0] daddr, dout;
  logic        dwe, dre;
  logic [31:0] din;
  logic        wb_we;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic        mem_cout, mem_v;

  int n_pass = 0;
  int n_total = 0;

  exmemwb_pipe #(.WIDTH(32), .AW(5), .FWD(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_immsel(id_immsel),
    .id_s(id_s), .id_cin(id_cin), .id_lw(id_lw), .id_sw(id_sw),
    .stall(stall), .daddr(daddr), .dout(dout), .dwe(dwe), .dre(dre),
    .din(din), .wb_we(wb_we), .wb_sel(wb_sel), .wb_data(wb_data),
    .mem_cout(mem_cout), .mem_v(mem_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one edge and settle 2 time units after it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic immsel, input logic [2:0] s, input logic cin,
                       input logic lw, input logic sw);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd; id_a = a; id_b = b;
    id_imm = imm; id_immsel = immsel; id_s = s; id_cin = cin; id_lw = lw; id_sw = sw;
  endtask

  task automatic nop();
    id_valid = 1'b0; id_lw = 1'b0; id_sw = 1'b0;
  endtask

  initial begin
    din = 32'h0000_1234;
    reset_n = 1'b0;
    // Reset with a valid instruction presented (r7 = r0 + 3)
    drive(5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd3, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_dwe", {31'd0, dwe}, 32'd0);
    chk("rst_dre", {31'd0, dre}, 32'd0);
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_wb_sel", {27'd0, wb_sel}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_flags", {30'd0, mem_cout, mem_v}, 32'd0);
    nop();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_wb_we", {31'd0, wb_we}, 32'd0);
    end

    // Back-to-back dependency: r1 = r0 + 5; r2 = r1 + r1 (stale operands 0)
    drive(5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd5, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd1, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
    #1 chk("b2b_stall", {31'd0, stall}, 32'd0);
    tick();
    nop();
    tick();
    chk("b2b_r1", {wb_we, 26'd0, wb_sel}, {1'b1, 26'd0, 5'd1});
    chk("b2b_r1_data", wb_data, 32'd5);
    tick();
    chk("b2b_r2", {wb_we, 26'd0, wb_sel}, {1'b1, 26'd0, 5'd2});
    chk("b2b_r2_data", wb_data, 32'h0000_000A);

    // Load-use: lw r3, 0x10(r0); r4 = r3 + 1
    drive(5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'h10, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0);
    tick();
    drive(5'd3, 5'd0, 5'd4, 32'd0, 32'd0, 32'd1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    #1 chk("lu_stall_on", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_stall_off", {31'd0, stall}, 32'd0);
    chk("lu_dre", {30'd0, dre, dwe}, 32'd2);
    chk("lu_daddr", daddr, 32'h10);
    tick();
    nop();
    chk("lu_r3", {wb_we, 26'd0, wb_sel}, {1'b1, 26'd0, 5'd3});
    chk("lu_r3_data", wb_data, 32'h1234);
    tick();
    chk("lu_bubble", {31'd0, wb_we}, 32'd0);
    tick();
    chk("lu_r4", {wb_we, 26'd0, wb_sel}, {1'b1, 26'd0, 5'd4});
    chk("lu_r4_data", wb_data, 32'h1235);

    // Store forwarding: r5 = r0 + 0xAB; sw r5, 0x20(r0)
    drive(5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'hAB, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd0, 5'd5, 5'd5, 32'd0, 32'd0, 32'h20, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
    #1 chk("st_stall", {31'd0, stall}, 32'd0);
    tick();
    nop();
    tick();
    chk("st_dwe", {30'd0, dwe, dre}, 32'd2);
    chk("st_daddr", daddr, 32'h20);
    chk("st_dout", dout, 32'hAB);
    chk("st_r5_data", wb_data, 32'hAB);
    tick();
    chk("st_dwe_once", {31'd0, dwe}, 32'd0);
    chk("st_no_wb", {31'd0, wb_we}, 32'd0);

    // Flags: 5 - 7; 0x7FFFFFFF + 1; 0xFFFFFFFF + 1
    drive(5'd9, 5'd10, 5'd8, 32'd5, 32'd7, 32'd0, 1'b0, 3'b011, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd11, 5'd0, 5'd12, 32'h7FFF_FFFF, 32'd0, 32'd1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd13, 5'd0, 5'd14, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    chk("sub_res", daddr, 32'hFFFF_FFFE);
    chk("sub_flags", {30'd0, mem_cout, mem_v}, 32'd0);
    tick();
    nop();
    chk("ovf_res", daddr, 32'h8000_0000);
    chk("ovf_flags", {30'd0, mem_cout, mem_v}, 32'd1);
    tick();
    chk("carry_res", daddr, 32'd0);
    chk("carry_flags", {30'd0, mem_cout, mem_v}, 32'd2);

    // r0 destination: r0 = r0 + 9; r6 = r0 + r0
    drive(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd9, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    chk("r0_no_wb", {31'd0, wb_we}, 32'd0);
    tick();
    chk("r6_wb", {wb_we, 26'd0, wb_sel}, {1'b1, 26'd0, 5'd6});
    chk("r6_data", wb_data, 32'd0);

    // Reset mid-operation: sw and a write in flight are discarded
    drive(5'd0, 5'd0, 5'd15, 32'd0, 32'd0, 32'h44, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd0, 5'd1, 5'd1, 32'd0, 32'd0, 32'h30, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
    tick();
    reset_n = 1'b0;
    nop();
    tick();
    reset_n = 1'b1;
    chk("mid_rst_dwe", {31'd0, dwe}, 32'd0);
    chk("mid_rst_wb", {31'd0, wb_we}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_quiet", {30'd0, dwe, wb_we}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
